// File: rtl/axicb_prio_rr_arbiter_if.sv
// Request/grant bundle for axicb_prio_rr_arbiter: the requester side is the master,
// the arbiter is the slave.
interface axicb_prio_rr_arbiter_if #(
    parameter int REQ_NB = 8,
    parameter int IDX_W  = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
);
    logic              en;
    logic [REQ_NB-1:0] req;
    logic [REQ_NB-1:0] grant;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    modport master (
        output en, req,
        input  grant, grant_valid, grant_idx
    );

    modport slave (
        input  en, req,
        output grant, grant_valid, grant_idx
    );
endinterface

// File: rtl/axicb_prio_rr_arbiter.sv
// N-requester arbiter: static priority levels, round-robin inside each level.
// Optional aging (macro AXICB_ARB_AGING_EN) promotes requesters that lost AGE_MAX times.
module axicb_prio_rr_arbiter #(
    parameter int                         REQ_NB      = 8,
    parameter int                         PRIO_LEVELS = 4,
    parameter int                         PRIO_W      = 3,
    parameter logic [REQ_NB*PRIO_W-1:0]   REQ_PRIO    = '0,
    parameter int                         AGE_MAX     = 15,
    parameter int                         IDX_W       = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    axicb_prio_rr_arbiter_if.slave arb
);

    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(REQ_NB - 1);

    logic [PRIO_W-1:0] prio [REQ_NB];
    for (genvar g = 0; g < REQ_NB; g++) begin : g_prio
        assign prio[g] = REQ_PRIO[g*PRIO_W +: PRIO_W];
    end

    logic [IDX_W-1:0]  ptr_q [PRIO_LEVELS];
    logic [IDX_W-1:0]  ptr_d [PRIO_LEVELS];
    logic [PRIO_W-1:0] active_lvl;
    logic [IDX_W-1:0]  lvl_ptr;
    logic [REQ_NB-1:0] lvl_cand;
    logic [REQ_NB-1:0] cand;
    logic [IDX_W-1:0]  start_ptr;
    logic [REQ_NB-1:0] grant_oh;
    logic [IDX_W-1:0]  win_idx;
    logic              grant_valid;
    logic              advance;
    logic              aged_any;

`ifdef AXICB_ARB_AGING_EN
    localparam int AGE_W = 8;

    logic [AGE_W-1:0]  age_q [REQ_NB];
    logic [AGE_W-1:0]  age_d [REQ_NB];
    logic [IDX_W-1:0]  aged_ptr_q;
    logic [IDX_W-1:0]  aged_ptr_d;
    logic [REQ_NB-1:0] aged;

    always_comb begin
        aged = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            aged[i] = arb.req[i] && (age_q[i] == AGE_W'(AGE_MAX));
        end
    end

    assign aged_any = |aged;
`else
    assign aged_any = 1'b0;
`endif

    // Active level and the candidate set searched this cycle.
    always_comb begin
        // NOTE: combinational blocks assign every output a default first and use
        // blocking '='; a missing default on any path infers a latch.
        active_lvl = '0;
        lvl_ptr    = PTR_RST;
        lvl_cand   = '0;
        for (int i = 0; i < REQ_NB; i++) begin
            if (arb.req[i] && (prio[i] > active_lvl)) active_lvl = prio[i];
        end
        for (int i = 0; i < REQ_NB; i++) begin
            lvl_cand[i] = arb.req[i] && (prio[i] == active_lvl);
        end
        for (int l = 0; l < PRIO_LEVELS; l++) begin
            if (int'(active_lvl) == l) lvl_ptr = ptr_q[l];
        end
`ifdef AXICB_ARB_AGING_EN
        cand      = aged_any ? aged : lvl_cand;
        start_ptr = aged_any ? aged_ptr_q : lvl_ptr;
`else
        cand      = lvl_cand;
        start_ptr = lvl_ptr;
`endif
    end

    // Round-robin pick: lowest candidate above the pointer, else lowest at or below it.
    logic              found_hi;
    logic [REQ_NB-1:0] hi_oh;
    logic [REQ_NB-1:0] lo_oh;
    logic [IDX_W-1:0]  hi_idx;
    logic [IDX_W-1:0]  lo_idx;

    always_comb begin
        found_hi = 1'b0;
        hi_oh    = '0;
        lo_oh    = '0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = REQ_NB - 1; i >= 0; i--) begin
            if (cand[i]) begin
                if (i > int'(start_ptr)) begin
                    found_hi  = 1'b1;
                    hi_oh     = '0;
                    hi_oh[i]  = 1'b1;
                    hi_idx    = IDX_W'(unsigned'(i));
                end else begin
                    lo_oh     = '0;
                    lo_oh[i]  = 1'b1;
                    lo_idx    = IDX_W'(unsigned'(i));
                end
            end
        end
        grant_oh = found_hi ? hi_oh  : lo_oh;
        win_idx  = found_hi ? hi_idx : lo_idx;
    end

    assign grant_valid     = |grant_oh;
    assign advance         = arb.en && grant_valid;
    assign arb.grant       = grant_oh;
    assign arb.grant_valid = grant_valid;
    assign arb.grant_idx   = win_idx;

    // Only the level that produced the winner moves its pointer.
    always_comb begin
        ptr_d = ptr_q;
        if (advance && !aged_any) begin
            for (int l = 0; l < PRIO_LEVELS; l++) begin
                if (int'(active_lvl) == l) ptr_d[l] = win_idx;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: sequential state uses non-blocking '<='; the pointer array is a
        // handful of flops whose reset value defines who wins first, so it is reset.
        if (!aresetn) begin
            for (int l = 0; l < PRIO_LEVELS; l++) ptr_q[l] <= PTR_RST;
        end else if (srst) begin
            for (int l = 0; l < PRIO_LEVELS; l++) ptr_q[l] <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef AXICB_ARB_AGING_EN
    always_comb begin
        age_d      = age_q;
        aged_ptr_d = aged_ptr_q;
        if (advance && aged_any) aged_ptr_d = win_idx;
        for (int i = 0; i < REQ_NB; i++) begin
            if (!arb.req[i] || (arb.en && grant_oh[i])) begin
                age_d[i] = '0;
            end else if (advance && (age_q[i] != AGE_W'(AGE_MAX))) begin
                age_d[i] = age_q[i] + AGE_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aged_ptr_q <= PTR_RST;
            for (int i = 0; i < REQ_NB; i++) age_q[i] <= '0;
        end else if (srst) begin
            aged_ptr_q <= PTR_RST;
            for (int i = 0; i < REQ_NB; i++) age_q[i] <= '0;
        end else begin
            aged_ptr_q <= aged_ptr_d;
            age_q      <= age_d;
        end
    end
`endif

endmodule
